// File: rtl/banked_regfile.sv
// Multi-bank register file: two registered read ports, one write-back port with
// half-word modes, write-to-read bypass and a per-bank background clear sequencer.
module banked_regfile #(
    parameter int DATA_W    = 32,
    parameter int REGS      = 32,
    parameter int NUM_BANKS = 3,
    parameter int BANK_W    = 2,
    parameter int ADDR_W    = 5
) (
    input  logic              clk_in,
    input  logic              reset_in,
    input  logic              rd_req_in,
    input  logic [BANK_W-1:0] bank_sel_in,
    input  logic [ADDR_W-1:0] rsa_in,
    input  logic [ADDR_W-1:0] rsb_in,
    output logic [DATA_W-1:0] rsa_val_out,
    output logic [DATA_W-1:0] rsb_val_out,
    output logic              rd_valid_out,
    output logic              rd_err_out,
    input  logic              wb_in,
    input  logic [BANK_W-1:0] wb_bank_sel_in,
    input  logic [ADDR_W-1:0] rd_in,
    input  logic [DATA_W-1:0] rd_val_in,
    input  logic [1:0]        wb_mode_in,
    output logic              wb_err_out,
    input  logic              clr_in,
    input  logic [BANK_W-1:0] clr_bank_in,
    output logic              clr_busy_out
);
    localparam int HALF = DATA_W / 2;

    typedef enum logic {IDLE, CLEAR} clr_state_t;

    logic [DATA_W-1:0] mem [NUM_BANKS][REGS];
    clr_state_t        state;
    logic [BANK_W-1:0] clr_bank;
    logic [ADDR_W-1:0] cnt;

    function automatic logic bank_valid(input logic [BANK_W-1:0] b);
        return int'(b) < NUM_BANKS;
    endfunction

    function automatic logic [DATA_W-1:0] merge(input logic [DATA_W-1:0] old_v,
                                                input logic [DATA_W-1:0] new_v,
                                                input logic [1:0]        mode);
        case (mode)
            2'b01:   return {old_v[DATA_W-1:HALF], new_v[HALF-1:0]};
            2'b10:   return {new_v[DATA_W-1:HALF], old_v[HALF-1:0]};
            default: return new_v;
        endcase
    endfunction

    logic              clr_start;
    logic              wb_busy;
    logic              wb_ok;
    logic              wb_commit;
    logic [DATA_W-1:0] wb_old;
    logic [DATA_W-1:0] wb_new;
    logic              rd_err;
    logic [DATA_W-1:0] rd_a;
    logic [DATA_W-1:0] rd_b;

    assign clr_start = (state == IDLE) && clr_in && bank_valid(clr_bank_in);

    // A bank that starts clearing on this edge already rejects writes.
    assign wb_busy   = ((state == CLEAR) && (clr_bank == wb_bank_sel_in)) ||
                       (clr_start && (clr_bank_in == wb_bank_sel_in));
    assign wb_ok     = wb_in && (wb_mode_in != 2'b11) && bank_valid(wb_bank_sel_in) && !wb_busy;
    assign wb_commit = wb_ok && !((wb_bank_sel_in == '0) && (rd_in == '0));

    always_comb begin
        wb_old = '0;
        if (bank_valid(wb_bank_sel_in))
            wb_old = mem[wb_bank_sel_in][rd_in];
        wb_new = merge(wb_old, rd_val_in, wb_mode_in);
    end

    always_comb begin
        rd_err = !bank_valid(bank_sel_in) || ((state == CLEAR) && (clr_bank == bank_sel_in));
        rd_a   = '0;
        rd_b   = '0;
        if (!rd_err) begin
            rd_a = mem[bank_sel_in][rsa_in];
            rd_b = mem[bank_sel_in][rsb_in];
            if (wb_commit && (wb_bank_sel_in == bank_sel_in)) begin
                if (rd_in == rsa_in) rd_a = wb_new;
                if (rd_in == rsb_in) rd_b = wb_new;
            end
            if (bank_sel_in == '0) begin
                if (rsa_in == '0) rd_a = '0;
                if (rsb_in == '0) rd_b = '0;
            end
        end
    end

    always_ff @(posedge clk_in) begin
        if (!reset_in) begin
            state        <= IDLE;
            clr_bank     <= '0;
            cnt          <= '0;
            clr_busy_out <= 1'b0;
            rsa_val_out  <= '0;
            rsb_val_out  <= '0;
            rd_valid_out <= 1'b0;
            rd_err_out   <= 1'b0;
            wb_err_out   <= 1'b0;
            for (int b = 0; b < NUM_BANKS; b++)
                for (int r = 0; r < REGS; r++)
                    mem[b][r] <= '0;
        end else begin
            rd_valid_out <= rd_req_in;
            rd_err_out   <= rd_req_in && rd_err;
            if (rd_req_in) begin
                rsa_val_out <= rd_a;
                rsb_val_out <= rd_b;
            end

            wb_err_out <= wb_in && !wb_ok;
            if (wb_commit)
                mem[wb_bank_sel_in][rd_in] <= wb_new;

            case (state)
                IDLE: begin
                    if (clr_start) begin
                        state        <= CLEAR;
                        clr_bank     <= clr_bank_in;
                        cnt          <= '0;
                        clr_busy_out <= 1'b1;
                    end
                end
                CLEAR: begin
                    mem[clr_bank][cnt] <= '0;
                    cnt <= cnt + 1'b1;
                    if (cnt == ADDR_W'(REGS - 1)) begin
                        state        <= IDLE;
                        clr_busy_out <= 1'b0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_banked_regfile.sv
// Scoreboard bench for banked_regfile: stimulus queues expectations, a negedge
// monitor pops them as the DUT presents read data and per-cycle status.
module tb_banked_regfile;
    localparam int DATA_W    = 32;
    localparam int REGS      = 32;
    localparam int NUM_BANKS = 3;
    localparam int BANK_W    = 2;
    localparam int ADDR_W    = 5;

    logic              clk_in = 1'b0;
    logic              reset_in;
    logic              rd_req_in;
    logic [BANK_W-1:0] bank_sel_in;
    logic [ADDR_W-1:0] rsa_in;
    logic [ADDR_W-1:0] rsb_in;
    logic [DATA_W-1:0] rsa_val_out;
    logic [DATA_W-1:0] rsb_val_out;
    logic              rd_valid_out;
    logic              rd_err_out;
    logic              wb_in;
    logic [BANK_W-1:0] wb_bank_sel_in;
    logic [ADDR_W-1:0] rd_in;
    logic [DATA_W-1:0] rd_val_in;
    logic [1:0]        wb_mode_in;
    logic              wb_err_out;
    logic              clr_in;
    logic [BANK_W-1:0] clr_bank_in;
    logic              clr_busy_out;

    always #5 clk_in = ~clk_in;

    banked_regfile #(
        .DATA_W(DATA_W), .REGS(REGS), .NUM_BANKS(NUM_BANKS), .BANK_W(BANK_W), .ADDR_W(ADDR_W)
    ) dut (
        .clk_in(clk_in), .reset_in(reset_in), .rd_req_in(rd_req_in),
        .bank_sel_in(bank_sel_in), .rsa_in(rsa_in), .rsb_in(rsb_in),
        .rsa_val_out(rsa_val_out), .rsb_val_out(rsb_val_out),
        .rd_valid_out(rd_valid_out), .rd_err_out(rd_err_out),
        .wb_in(wb_in), .wb_bank_sel_in(wb_bank_sel_in), .rd_in(rd_in),
        .rd_val_in(rd_val_in), .wb_mode_in(wb_mode_in), .wb_err_out(wb_err_out),
        .clr_in(clr_in), .clr_bank_in(clr_bank_in), .clr_busy_out(clr_busy_out)
    );

    typedef struct {
        string             name;
        logic [DATA_W-1:0] a;
        logic [DATA_W-1:0] b;
        logic              err;
    } rd_exp_t;

    typedef struct {
        logic valid;
        logic wb_err;
        logic busy;
    } cyc_exp_t;

    rd_exp_t  rq[$];
    cyc_exp_t wq[$];
    rd_exp_t  pend_rd;
    logic     pend_wberr;
    int       n_vec = 0;
    int       n_bad = 0;
    int       busy_cnt = 0;

    task automatic check(input string nm, input logic [DATA_W-1:0] act, input logic [DATA_W-1:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s @%0t: got %h, required %h", nm, $time, act, exp);
        end
    endtask

    always @(negedge clk_in) begin
        cyc_exp_t e;
        rd_exp_t  r;
        if (wq.size() > 0) begin
            e = wq.pop_front();
            check("rd_valid", 32'(rd_valid_out), 32'(e.valid));
            check("wb_err", 32'(wb_err_out), 32'(e.wb_err));
            check("clr_busy", 32'(clr_busy_out), 32'(e.busy));
            if (rd_valid_out) begin
                if (rq.size() == 0) begin
                    check("unexpected_read", 32'(rd_valid_out), 32'd0);
                end else begin
                    r = rq.pop_front();
                    check({r.name, ".a"}, rsa_val_out, r.a);
                    check({r.name, ".b"}, rsb_val_out, r.b);
                    check({r.name, ".err"}, 32'(rd_err_out), 32'(r.err));
                end
            end
        end
    end

    task automatic idle();
        reset_in       = 1'b1;
        rd_req_in      = 1'b0;
        bank_sel_in    = '0;
        rsa_in         = '0;
        rsb_in         = '0;
        wb_in          = 1'b0;
        wb_bank_sel_in = '0;
        rd_in          = '0;
        rd_val_in      = '0;
        wb_mode_in     = 2'b00;
        clr_in         = 1'b0;
        clr_bank_in    = '0;
        pend_wberr     = 1'b0;
    endtask

    task automatic rd(input string nm, input logic [BANK_W-1:0] bank,
                      input logic [ADDR_W-1:0] a, input logic [ADDR_W-1:0] b,
                      input logic [DATA_W-1:0] ea, input logic [DATA_W-1:0] eb, input logic ee);
        rd_req_in    = 1'b1;
        bank_sel_in  = bank;
        rsa_in       = a;
        rsb_in       = b;
        pend_rd.name = nm;
        pend_rd.a    = ea;
        pend_rd.b    = eb;
        pend_rd.err  = ee;
    endtask

    task automatic wr(input logic [BANK_W-1:0] bank, input logic [ADDR_W-1:0] r,
                      input logic [DATA_W-1:0] v, input logic [1:0] mode, input logic ewe);
        wb_in          = 1'b1;
        wb_bank_sel_in = bank;
        rd_in          = r;
        rd_val_in      = v;
        wb_mode_in     = mode;
        pend_wberr     = ewe;
    endtask

    task automatic clr(input logic [BANK_W-1:0] bank);
        clr_in      = 1'b1;
        clr_bank_in = bank;
    endtask

    task automatic step();
        cyc_exp_t c;
        if (!reset_in)
            busy_cnt = 0;
        else if (busy_cnt > 0)
            busy_cnt--;
        else if (clr_in && (int'(clr_bank_in) < NUM_BANKS))
            busy_cnt = REGS;
        c.valid  = reset_in && rd_req_in;
        c.wb_err = reset_in && pend_wberr;
        c.busy   = busy_cnt > 0;
        wq.push_back(c);
        if (reset_in && rd_req_in)
            rq.push_back(pend_rd);
        @(posedge clk_in);
        #1;
        idle();
    endtask

    task automatic rst_cycle();
        reset_in = 1'b0;
        step();
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout, required completion");
        $fatal(1, "watchdog");
    end

    initial begin
        idle();
        rst_cycle();
        rst_cycle();
        rd("reset_read", 2'd1, 5'd5, 5'd0, 32'h0, 32'h0, 1'b0); step();

        // Half-word merge on bank0 r3
        wr(2'd0, 5'd3, 32'hAAAA5555, 2'b00, 1'b0); step();
        wr(2'd0, 5'd3, 32'h1234FFFF, 2'b10, 1'b0); step();
        rd("half_upper", 2'd0, 5'd3, 5'd0, 32'h12345555, 32'h0, 1'b0); step();
        wr(2'd0, 5'd3, 32'h0000BEEF, 2'b01, 1'b0); step();
        rd("half_lower", 2'd0, 5'd3, 5'd3, 32'h1234BEEF, 32'h1234BEEF, 1'b0); step();

        // Bypass, full and merged, ports independent
        wr(2'd2, 5'd7, 32'hDEADBEEF, 2'b00, 1'b0);
        rd("bypass_full", 2'd2, 5'd7, 5'd7, 32'hDEADBEEF, 32'hDEADBEEF, 1'b0); step();
        wr(2'd2, 5'd7, 32'h00001111, 2'b01, 1'b0);
        rd("bypass_half", 2'd2, 5'd6, 5'd7, 32'h0, 32'hDEAD1111, 1'b0); step();

        // Bank0 r0 is hardwired zero, write is not an error
        wr(2'd0, 5'd0, 32'hFFFFFFFF, 2'b00, 1'b0);
        rd("r0_bypass", 2'd0, 5'd0, 5'd3, 32'h0, 32'h1234BEEF, 1'b0); step();
        rd("r0_after", 2'd0, 5'd0, 5'd0, 32'h0, 32'h0, 1'b0); step();

        // Errors
        rd("bad_bank", 2'd3, 5'd3, 5'd7, 32'h0, 32'h0, 1'b1); step();
        wr(2'd0, 5'd3, 32'h0, 2'b11, 1'b1); step();
        rd("mode11_kept", 2'd0, 5'd3, 5'd3, 32'h1234BEEF, 32'h1234BEEF, 1'b0); step();
        wr(2'd3, 5'd1, 32'h55, 2'b00, 1'b1); step();
        clr(2'd3); step();

        // Fill bank1, then clear it
        for (int i = 0; i < REGS; i++) begin
            wr(2'd1, ADDR_W'(i), 32'hA5A50000 + 32'(i), 2'b00, 1'b0); step();
        end
        rd("fill_b1", 2'd1, 5'd5, 5'd31, 32'hA5A50005, 32'hA5A5001F, 1'b0); step();

        clr(2'd1);
        wr(2'd1, 5'd4, 32'h1, 2'b00, 1'b1); step();
        wr(2'd0, 5'd9, 32'h00000099, 2'b00, 1'b0); step();
        rd("b0_during_clr", 2'd0, 5'd9, 5'd3, 32'h99, 32'h1234BEEF, 1'b0); step();
        rd("b1_during_clr", 2'd1, 5'd5, 5'd6, 32'h0, 32'h0, 1'b1); step();
        wr(2'd1, 5'd2, 32'h77, 2'b00, 1'b1); step();
        clr(2'd1); step();
        rd("b2_during_clr", 2'd2, 5'd7, 5'd7, 32'hDEAD1111, 32'hDEAD1111, 1'b0); step();
        for (int i = 0; i < 26; i++) step();
        for (int i = 0; i < REGS / 2; i++) begin
            rd("b1_cleared", 2'd1, ADDR_W'(2 * i), ADDR_W'(2 * i + 1), 32'h0, 32'h0, 1'b0); step();
        end

        // Reset in the middle of a bank0 clear
        wr(2'd2, 5'd1, 32'h5, 2'b00, 1'b0); step();
        clr(2'd0); step();
        for (int i = 0; i < 9; i++) step();
        rst_cycle();
        rd("rst_b0", 2'd0, 5'd3, 5'd9, 32'h0, 32'h0, 1'b0); step();
        rd("rst_b2", 2'd2, 5'd7, 5'd1, 32'h0, 32'h0, 1'b0); step();
        rd("rst_b1", 2'd1, 5'd0, 5'd31, 32'h0, 32'h0, 1'b0); step();

        @(negedge clk_in);
        #1;
        check("rd_queue_drain", 32'(rq.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/banked_regfile.md
Name: banked_regfile

Overview:
- Parametrised multi-bank register file for the main core. Replaces the fixed three-bank GP/SYS/GBL wrapper.
- Provides NUM_BANKS banks of REGS registers each, two registered read ports, one write-back port with full/half-word modes, write-to-read bypass, and a per-bank background clear sequencer.
- Sits between decode (read side) and write-back stage.

Parameters:
DATA_W, 32, register width in bits; must be even
REGS, 32, registers per bank; power of 2
NUM_BANKS, 3, number of banks; 1..(2**BANK_W)
BANK_W, 2, width of bank select fields
ADDR_W, 5, register address width; REGS = 2**ADDR_W

Ports:
clk_in  in  1  clock; all logic on rising edge
reset_in  in  1  synchronous, active-low reset
rd_req_in  in  1  read request; operands sampled this cycle
bank_sel_in  in  BANK_W  bank for both read ports
rsa_in  in  ADDR_W  read port A address
rsb_in  in  ADDR_W  read port B address
rsa_val_out  out  DATA_W  port A data, registered
rsb_val_out  out  DATA_W  port B data, registered
rd_valid_out  out  1  read data valid, one cycle after rd_req_in
rd_err_out  out  1  read targeted an invalid bank or a bank being cleared
wb_in  in  1  write-back strobe
wb_bank_sel_in  in  BANK_W  write-back bank
rd_in  in  ADDR_W  write-back destination register
rd_val_in  in  DATA_W  write-back data
wb_mode_in  in  2  00 full word, 01 lower half, 10 upper half, 11 reserved
wb_err_out  out  1  registered pulse: last write was dropped
clr_in  in  1  start clearing bank clr_bank_in; single-cycle pulse
clr_bank_in  in  BANK_W  bank to clear
clr_busy_out  out  1  clear sequencer active

Behaviour:
- Reset (reset_in=0 at a clock edge):
  - All registers in all banks become 0.
  - All outputs become 0.
  - Clear FSM goes to IDLE.
  - Reset overrides any in-progress clear or write.
- Bank 0, register 0 reads as 0 permanently. Writes to it are silently ignored and are not errors.
- Read path, 1-cycle latency:
  - On an edge with rd_req_in=1: rsa_val_out/rsb_val_out <= contents at (bank_sel_in, rsa_in/rsb_in); rd_valid_out <= 1.
  - On an edge with rd_req_in=0: rd_valid_out <= 0, and data outputs hold their previous values.
  - Ports A and B are independent. rsb_val_out always sources rsb_in.
- Read errors: if bank_sel_in >= NUM_BANKS, or the selected bank is being cleared, that read returns 0 on both ports with rd_err_out=1 and rd_valid_out=1.
- Bypass: a write and a read to the same (bank, reg) in the same cycle return the post-write value.
  - Half-word writes are merged with the old value before forwarding.
  - The bypass also applies to each port independently.
- Write-back: when wb_in=1 at an edge and the write is legal, the register updates at that edge.
  - 00: whole word.
  - 01: bits [DATA_W/2-1:0] only.
  - 10: bits [DATA_W-1:DATA_W/2] only.
- Dropped writes (register unchanged, wb_err_out=1 for one cycle) occur when any of the following hold:
  - wb_mode_in=11;
  - wb_bank_sel_in >= NUM_BANKS;
  - the target bank is being cleared.
- Clear FSM:
  - States:
    - IDLE: clr_busy_out=0.
    - CLEAR: clr_busy_out=1; counter cnt runs 0..REGS-1 and writes 0 to (clr_bank, cnt) each cycle.
  - IDLE->CLEAR on clr_in=1 with clr_bank_in < NUM_BANKS. On that same edge, clr_bank latches and cnt <= 0.
  - clr_in with an invalid bank is ignored.
  - CLEAR->IDLE on the edge where cnt=REGS-1. A clear therefore lasts exactly REGS cycles of clr_busy_out=1.
  - clr_in while in CLEAR is ignored; there is no queueing or restart.
- Reads and writes to other banks proceed normally during a clear.
- Simultaneous wb_in and clr_in targeting the same bank: the write is dropped with wb_err_out=1, because the bank becomes busy from that edge.

Test Plan:
- Reset then read: reset_in=0 for 2 cycles, then a read of bank1 r5 -> rsa_val_out=0, rd_valid_out=1 one cycle after rd_req_in.
- Half-word merge: full-write bank0 r3=0xAAAA5555, then mode 10 with 0x1234FFFF -> read returns 0x12345555; then mode 01 with 0x0000BEEF -> read returns 0x1234BEEF.
- Bypass and r0: in the same cycle, write bank2 r7=0xDEADBEEF and read rsa=7, rsb=7 -> both ports return 0xDEADBEEF next cycle. Write bank0 r0=0xFFFFFFFF -> reads as 0 with wb_err_out=0.
- Errors: bank_sel_in=3 with NUM_BANKS=3 -> outputs 0, rd_err_out=1. wb_mode_in=11 -> register unchanged, wb_err_out=1 for exactly 1 cycle.
- Clear sequence: fill bank1 with nonzero values, pulse clr_in for bank1 -> clr_busy_out high exactly 32 cycles; bank0 writes and reads stay correct during the clear; a bank1 write mid-clear sets wb_err_out; afterwards all bank1 registers read 0.
- Reset mid-clear: assert reset_in=0 at clear cycle 10 -> clr_busy_out=0 next cycle and all banks read 0.
